// File: rtl/posit_arb_pkg.sv
// Shared types and constants for the posit adder arbiter.
// Occupancy encoding matches {s1_valid, s2_valid}.
package posit_arb_pkg;

  localparam int N_DEF    = 32;
  localparam int ES_DEF   = 4;
  localparam int NREQ_DEF = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S2_ONLY = 2'b01,
    S1_ONLY = 2'b10,
    FULL    = 2'b11
  } occ_t;

  localparam logic [N_DEF-1:0] POSIT_NAR =
    {1'b1, {(N_DEF-1){1'b0}}};
  localparam logic [N_DEF-1:0] POSIT_ZERO = '0;

  function automatic occ_t occ_of(
    input logic s1,
    input logic s2
  );
    return occ_t'({s1, s2});
  endfunction

endpackage

// File: rtl/Posit_Adder.sv
// Combinational posit<N,ES> adder, round to nearest even.
// Results saturate at maxpos/minpos; NaR propagates.
module Posit_Adder #(
  parameter int N  = 32,
  parameter int ES = 4
) (
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic [N-1:0] OUT
);

  localparam int FW = N - ES;
  localparam int MW = FW + 1;
  localparam int AW = 2 * MW + 2;
  localparam int TW = N + ES + AW;

  localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINP = {{(N-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic               sgn;
    logic signed [15:0] scl;
    logic [MW-1:0]      man;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] p);
    dec_t         d;
    logic [N-1:0] v;
    logic [N-1:0] rem;
    logic         rb;
    logic         stop;
    int           run;
    int           k;
    v    = p[N-1] ? -p : p;
    rb   = v[N-2];
    run  = 0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && v[i] == rb) run++;
      else stop = 1'b1;
    end
    rem   = v << (run + 2);
    k     = rb ? run - 1 : -run;
    d.sgn = p[N-1];
    d.scl = 16'(k * (2**ES) + int'(rem[N-1 -: ES]));
    d.man = {1'b1, rem[N-ES-1:0]};
    return d;
  endfunction

  function automatic int lzc(input logic [AW-1:0] x);
    int   n;
    logic stop;
    n    = 0;
    stop = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!stop && !x[i]) n++;
      else stop = 1'b1;
    end
    return n;
  endfunction

  dec_t          da, db, dl, ds;
  logic          a_big;
  logic [AW-1:0] xl, xs, sum, msk;
  logic [AW-2:0] norm;
  logic [TW-1:0] xt;
  logic [N-2:0]  body;
  logic [N-1:0]  res;
  logic [ES-1:0] e;
  logic          stk, g, rnd;
  int            diff, sh, scl, k, run;

  always_comb begin
    da    = decode(IN1);
    db    = decode(IN2);
    a_big = ($signed(da.scl) > $signed(db.scl)) ||
            ((da.scl == db.scl) && (da.man >= db.man));
    dl    = a_big ? da : db;
    ds    = a_big ? db : da;
    diff  = int'($signed(dl.scl)) - int'($signed(ds.scl));
    xl    = {1'b0, dl.man, {(AW-MW-1){1'b0}}};
    xs    = {1'b0, ds.man, {(AW-MW-1){1'b0}}};
    msk   = '0;
    if (diff >= AW) begin
      stk = 1'b1;
      xs  = '0;
    end else begin
      msk = ~({AW{1'b1}} << diff);
      stk = |(xs & msk);
      xs  = xs >> diff;
    end
    xs[0] = xs[0] | stk;
    sum   = (dl.sgn == ds.sgn) ? xl + xs : xl - xs;
    sh    = lzc(sum);
    norm  = (AW-1)'(sum << sh);
    scl   = int'($signed(dl.scl)) + 1 - sh;
    k     = scl >>> ES;
    e     = scl[ES-1:0];
    // Regime run fills from the left with its own bit value.
    run   = (k >= 0) ? k + 1 : -k;
    xt    = {(k < 0), e, norm, {N{1'b0}}};
    xt    = xt >> run;
    if (k >= 0) xt = xt | ~({TW{1'b1}} >> run);
    body  = xt[TW-1 -: N-1];
    g     = xt[TW-N];
    stk   = |xt[TW-N-1:0];
    rnd   = g & (body[0] | stk);
    res   = {1'b0, body + (N-1)'(rnd)};
    if (k >= N - 2) res = MAXP;
    else if (k <= -(N - 1)) res = MINP;
    if (IN1 == NAR || IN2 == NAR) OUT = NAR;
    else if (IN1 == '0) OUT = IN2;
    else if (IN2 == '0) OUT = IN1;
    else if (sum == '0) OUT = '0;
    else OUT = dl.sgn ? -res : res;
  end

endmodule

// File: rtl/posit_rr_arbiter.sv
// Round-robin pick starting at ptr; grant only when enabled.
// idx reports the winner even when the grant is suppressed.
module posit_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic           hit;
  logic [IDW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IDW'((int'(ptr) + i) % NREQ);
      if (!hit && req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
    if (en && hit) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/posit_add_arbiter.sv
// Shares one posit adder among NREQ requesters through
// a two-stage pipeline with round-robin operand grants.
module posit_add_arbiter
  import posit_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ES   = ES_DEF,
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][N-1:0] req_a,
  input  logic [NREQ-1:0][N-1:0] req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [N-1:0]           rsp_sum,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  logic           s1_valid_q, s1_valid_d;
  logic [N-1:0]   s1_a_q, s1_a_d;
  logic [N-1:0]   s1_b_q, s1_b_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           s2_valid_q, s2_valid_d;
  logic [N-1:0]   s2_sum_q, s2_sum_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]    ops_done_q, ops_done_d;

  occ_t           occ;
  logic           s2_free, s1_adv, s1_free;
  logic           arb_en, acc, rsp_fire;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   add_sum;

  posit_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  Posit_Adder #(.N(N), .ES(ES)) u_add (
    .IN1 (s1_a_q),
    .IN2 (s1_b_q),
    .OUT (add_sum)
  );

  always_comb begin
    occ      = occ_of(s1_valid_q, s2_valid_q);
    s2_free  = !s2_valid_q || rsp_ready[s2_id_q];
    s1_adv   = s1_valid_q && s2_free;
    s1_free  = !s1_valid_q || s1_adv;
    rsp_fire = s2_valid_q && rsp_ready[s2_id_q];
    // Holding reset keeps req_ready low even with requests pending.
    arb_en   = s1_free && nreset;
    acc      = |gnt;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    ops_done_d = ops_done_q + 16'(rsp_fire);
    if (acc) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[gnt_idx];
      s1_b_d     = req_b[gnt_idx];
      s1_id_d    = gnt_idx;
      rr_ptr_d   = (int'(gnt_idx) == NREQ - 1) ?
                   '0 : gnt_idx + IDW'(1);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = add_sum;
      s2_id_d    = s1_id_q;
    end else if (rsp_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= N'(POSIT_ZERO);
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
      ops_done_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = NREQ'(s2_valid_q) << s2_id_q;
  assign rsp_sum   = s2_sum_q;
  assign busy      = (occ != EMPTY);
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed bench for posit_add_arbiter, NREQ=2.
// Inputs change 1ns after rising edges; outputs sampled on falling edges.
module tb_posit_add_arbiter;

  localparam int N    = 32;
  localparam int ES   = 4;
  localparam int NREQ = 2;

  logic                   clock = 1'b0;
  logic                   nreset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [N-1:0]           rsp_sum;
  logic                   busy;
  logic [15:0]            ops_done;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  posit_add_arbiter #(.N(N), .ES(ES), .NREQ(NREQ)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset    = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_a     = '0;
    req_b     = '0;
    #3;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b want=00", req_ready);
    end
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b/%b want=00/0", rsp_valid, busy);
    end
    checks++;
    if (rsp_sum !== 32'h0 || ops_done !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0/0", rsp_sum, ops_done);
    end
    req_valid = 2'b00;
    next_cycle();
    nreset = 1'b1;
    next_cycle();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_release got=%b/%b want=0/00", busy, rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_single();
    req_a[0]  = 32'h4000_0000;
    req_b[0]  = 32'h4000_0000;
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready got=%b want=01", req_ready);
    end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_s1 got=%b/%b want=1/00", busy, rsp_valid);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_sum !== 32'h4200_0000) begin
      failures++;
      $display("FAIL single_rsp got=%b/%h want=01/42000000",
               rsp_valid, rsp_sum);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (ops_done !== 16'd1 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done got=%0d/%b/%b want=1/00/0",
               ops_done, rsp_valid, busy);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] erdy [7];
    logic [1:0] ersp [7];
    logic [31:0] esum;
    erdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    ersp = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    do_reset();
    req_a[0]  = 32'h4000_0000;
    req_b[0]  = 32'h4000_0000;
    req_a[1]  = 32'h0000_0000;
    req_b[1]  = 32'h54AA_A545;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) req_valid = 2'b00;
      @(negedge clock);
      checks++;
      if (req_ready !== erdy[i]) begin
        failures++;
        $display("FAIL contend_grant[%0d] got=%b want=%b",
                 i, req_ready, erdy[i]);
      end
      esum = (ersp[i] == 2'b01) ? 32'h4200_0000 : 32'h54AA_A545;
      checks++;
      if (rsp_valid !== ersp[i] ||
          (ersp[i] != 2'b00 && rsp_sum !== esum)) begin
        failures++;
        $display("FAIL contend_rsp[%0d] got=%b/%h want=%b/%h",
                 i, rsp_valid, rsp_sum, ersp[i], esum);
      end
      next_cycle();
    end
    checks++;
    if (ops_done !== 16'd4) begin
      failures++;
      $display("FAIL contend_count got=%0d want=4", ops_done);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  erdy [10];
    logic [1:0]  ersp [10];
    logic [31:0] esum [10];
    logic [31:0] oa [4];
    logic [31:0] ob [4];
    int          opi [10];
    erdy = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
             2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    ersp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01,
             2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    esum = '{32'h0, 32'h0, 32'h4200_0000, 32'h4200_0000,
             32'h4200_0000, 32'h4200_0000, 32'h4000_0000,
             32'h54AA_A545, 32'h0000_0000, 32'h0};
    oa   = '{32'h4000_0000, 32'h4000_0000, 32'h54AA_A545, 32'h7FC0_0000};
    ob   = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8040_0000};
    opi  = '{0, 1, 2, 2, 2, 2, 3, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rsp_ready = (i < 5) ? 2'b10 : 2'b11;
      req_valid = (i < 7) ? 2'b01 : 2'b00;
      req_a[0]  = oa[opi[i]];
      req_b[0]  = ob[opi[i]];
      @(negedge clock);
      checks++;
      if (req_ready !== erdy[i]) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%b want=%b",
                 i, req_ready, erdy[i]);
      end
      checks++;
      if (rsp_valid !== ersp[i] ||
          (ersp[i] != 2'b00 && rsp_sum !== esum[i])) begin
        failures++;
        $display("FAIL bp_rsp[%0d] got=%b/%h want=%b/%h",
                 i, rsp_valid, rsp_sum, ersp[i], esum[i]);
      end
      next_cycle();
    end
    checks++;
    if (ops_done !== 16'd4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done got=%0d/%b want=4/0", ops_done, busy);
    end
  endtask

  task automatic test_specials();
    logic [31:0] sa [3];
    logic [31:0] sb [3];
    logic [31:0] ex [3];
    sa = '{32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000};
    sb = '{32'h2A2A_A456, 32'h54AA_A545, 32'h8040_0000};
    ex = '{posit_arb_pkg::POSIT_NAR, 32'h54AA_A545,
           posit_arb_pkg::POSIT_ZERO};
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 3) ? 2'b10 : 2'b00;
      if (i < 3) begin
        req_a[1] = sa[i];
        req_b[1] = sb[i];
      end
      @(negedge clock);
      checks++;
      if (req_ready !== ((i < 3) ? 2'b10 : 2'b00)) begin
        failures++;
        $display("FAIL spec_ready[%0d] got=%b", i, req_ready);
      end
      if (i >= 2 && i < 5) begin
        checks++;
        if (rsp_valid !== 2'b10 || rsp_sum !== ex[i-2]) begin
          failures++;
          $display("FAIL spec_sum[%0d] got=%b/%h want=10/%h",
                   i - 2, rsp_valid, rsp_sum, ex[i-2]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    req_a[0]  = 32'h4000_0000;
    req_b[0]  = 32'h4000_0000;
    next_cycle();
    next_cycle();
    @(negedge clock);
    checks++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || rsp_valid !== 2'b01) begin
      failures++;
      $display("FAIL mid_full got=%b/%b/%b want=00/1/01",
               req_ready, busy, rsp_valid);
    end
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_async got=%b/%b/%b want=00/00/0",
               req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_sum !== 32'h0 || ops_done !== 16'h0) begin
      failures++;
      $display("FAIL mid_async_data got=%h/%h want=0/0",
               rsp_sum, ops_done);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    next_cycle();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale[%0d] got=%b/%b want=00/0",
                 i, rsp_valid, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 65540; i++) begin
      req_valid = (i < 65536) ? 2'b11 : 2'b00;
      @(negedge clock);
      if (i == 1000) begin
        checks++;
        if (ops_done !== 16'd998) begin
          failures++;
          $display("FAIL wrap_rate got=%0d want=998", ops_done);
        end
      end
      if (i == 65537) begin
        checks++;
        if (ops_done !== 16'hFFFF) begin
          failures++;
          $display("FAIL wrap_max got=%h want=ffff", ops_done);
        end
      end
      if (i == 65538) begin
        checks++;
        if (ops_done !== 16'h0000) begin
          failures++;
          $display("FAIL wrap_zero got=%h want=0000", ops_done);
        end
      end
      if (i == 65539) begin
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
          failures++;
          $display("FAIL wrap_idle got=%b/%b want=0/00", busy, rsp_valid);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_specials();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_add_arbiter.md
# posit_add_arbiter

Shares one combinational `Posit_Adder` (N=32, ES=4) between NREQ requesters. Each requester uses a valid/ready operand channel and a valid/ready response channel. Grants are round-robin, one per cycle. The adder sits between a registered operand stage and a registered result stage, giving two-cycle latency and one add per cycle sustained throughput. The block is the front end through which posit compute units reach the adder.

## Interface
Parameters:
- `N`, 32, posit width
- `ES`, 4, exponent field width
- `NREQ`, 2, requester count (2..8)
- `IDW`, `$clog2(NREQ)`, requester-index width (localparam)

Ports:
- `clock`  in  1  system clock, rising edge
- `nreset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  operand pair offered, one bit per requester
- `req_ready`  out  NREQ  operand pair accepted this cycle (one-hot or zero)
- `req_a`  in  NREQ×N  operand A per requester
- `req_b`  in  NREQ×N  operand B per requester
- `rsp_valid`  out  NREQ  sum available for the indicated requester (one-hot or zero)
- `rsp_ready`  in  NREQ  requester consumes the sum
- `rsp_sum`  out  N  posit sum, shared bus
- `busy`  out  1  any stage occupied
- `ops_done`  out  16  count of completed responses, wraps

Clock is `clock`. Reset `nreset` is asynchronous and active-low.

## Operation
- Stage 1 registers: `s1_valid`, `s1_a`, `s1_b`, `s1_id`. They feed `Posit_Adder` IN1/IN2.
- Stage 2 registers: `s2_valid`, `s2_sum`, `s2_id`. They drive `rsp_sum`, and `rsp_valid = s2_valid << s2_id`.
- Occupancy state {s1_valid, s2_valid} is one of four:
  - EMPTY
  - S1_ONLY
  - S2_ONLY
  - FULL
- Pipeline control signals:
  - `s2_free = !s2_valid || rsp_ready[s2_id]`.
  - `s1_adv = s1_valid && s2_free`.
  - `s1_free = !s1_valid || s1_adv`.
- Arbitration is combinational. It picks the first requester with `req_valid` set, searching from pointer `rr_ptr` upward, modulo NREQ.
  - `req_ready` is asserted for that requester only, and only if `s1_free`.
- On acceptance:
  - Stage 1 loads that requester's a/b/id.
  - `rr_ptr` becomes granted index + 1, mod NREQ.
  - Without acceptance, `rr_ptr` holds.
- On `s1_adv`, stage 2 loads the adder output and `s1_id`.
- Response drop:
  - `s2_valid` clears when the response is consumed and stage 1 does not advance.
  - If stage 1 advances in the same cycle as the consume, `s2_valid` stays 1 and stage 2 reloads.
- Response hold: while `rsp_valid` is high and `rsp_ready` is low, `rsp_sum` and the id are held stable.
- `ops_done` increments on each response handshake. It wraps from 0xFFFF to 0.
- `busy = s1_valid || s2_valid`.
- Arithmetic, including zero and NaR (0x8000_0000) handling, is done entirely by `Posit_Adder`. The controller never inspects operand values.
- Requesters must hold a/b stable while `req_valid` is high and `req_ready` is low. Deasserting `req_valid` before acceptance is permitted and cancels the request.

## Timing
- Reset values:
  - all valids 0
  - `req_ready` 0
  - `rsp_valid` 0
  - `rsp_sum` 0
  - `busy` 0
  - `ops_done` 0
  - `rr_ptr` 0
- Latency: a request accepted at clock edge k produces `rsp_valid` high after edge k+1, i.e. first visible in cycle k+2.
- Throughput: one accept per cycle when the consuming requester holds `rsp_ready` high.
- Backpressure: while stage 2 is stalled and stage 1 is full, `req_ready` is all zero.
- Simultaneous consume and accept in FULL state: all three transfers occur in the same cycle and there is no bubble.
- Reset asserted mid-operation: in-flight operations are discarded, outputs go to reset values immediately (asynchronously), and no response is emitted after release.

## Structure
- Shared package `posit_arb_pkg`:
  - default `N`/`ES`/`NREQ`
  - `occ_t` enum {EMPTY, S1_ONLY, S2_ONLY, FULL}
  - constant `POSIT_NAR = 1 << (N-1)`
  - constant `POSIT_ZERO = '0`
- One sub-module, `posit_rr_arbiter`: parameterised NREQ, inputs req/ptr/enable, outputs one-hot grant and index.
- `Posit_Adder #(.N(N), .ES(ES))` is instantiated once, unmodified.

## Test plan
- Single op, NREQ=2, `rsp_ready` held 1: requester 0 sends 0x40000000 + 0x40000000. Expect `rsp_valid` = 2'b01 two cycles later with `rsp_sum` = 0x42000000, and `ops_done` = 1.
- Contention: both requesters hold `req_valid` for 4 cycles. Grants must alternate 0,1,0,1. Responses return in that order with the matching ids and no bubbles.
- Backpressure: `rsp_ready[0]` is held 0 for 5 cycles with continuous requests. `req_ready` goes to 0 once FULL. `rsp_sum` stays stable. On release, the queued response follows in the next cycle.
- Specials: 0x80000000 + 0x2A2AA456 gives 0x80000000. 0x00000000 + 0x54AAA545 gives 0x54AAA545. 0x7FC00000 + 0x80400000 gives 0x00000000.
- Reset: assert `nreset` while state is FULL. All outputs go to 0 without waiting for a clock edge. After release, `busy` = 0 and no stale response appears.
- Wrap: 65536 responses; `ops_done` returns to 0x0000.
